aes_iter_core: RTL and testbench
================================

# aes_iter_core

Iterative, parametrised AES encryption core and the successor to the fixed AES-128 `AES` block. It accepts one plaintext block and key through a valid/ready handshake and executes one AES round per clock, expanding the key on the fly. It then presents the ciphertext through a valid/ready output handshake. It supports AES-128 and AES-256 and sits between a block-source controller and a ciphertext sink, for example a CTR/ECB wrapper.

## Interface
- `KEY_BITS`, default 128: key length. Legal values are 128 and 256; any other value is an elaboration error. This sets `NR` = 10 or 14 rounds.
- `i_AES_clk`  in  1: single clock; all state updates on the rising edge.
- `i_AES_rst_n`  in  1: asynchronous, active-low reset.
- `i_AES_valid`  in  1: input block and key are valid.
- `o_AES_ready`  out  1: core can accept a block; high only in IDLE.
- `i_AES_plain_text`  in  128: plaintext. Byte 0 is bits [127:120]; bytes are ordered column-major per FIPS-197.
- `i_AES_key_in`  in  KEY_BITS: cipher key, with the same byte ordering as the plaintext.
- `o_AES_valid`  out  1: ciphertext is valid.
- `i_AES_ready`  in  1: the sink accepts the ciphertext.
- `o_AES_data_encrypted`  out  128: ciphertext.

## Operation
- FSM states: IDLE, ROUND, DONE.
- **IDLE:**
  - `o_AES_ready`=1.
  - On `i_AES_valid`&&`o_AES_ready` (accept):
    - state register <= plaintext XOR round key 0.
    - Key window <= key.
    - Round counter <= 1.
    - Go to ROUND.
- **ROUND:**
  - Each cycle applies SubBytes, ShiftRows, MixColumns and AddRoundKey(rk[cnt]), then increments `cnt`.
  - On `cnt`==`NR`, MixColumns is skipped (final round); the result is loaded into the output register and the FSM goes to DONE.
- **DONE:**
  - `o_AES_valid`=1 and `o_AES_data_encrypted` holds the result.
  - On `i_AES_ready`: go to IDLE.
  - Otherwise hold, with data stable and valid held high.
- **Key schedule, `KEY_BITS`=128:**
  - 128-bit window holding words w0..w3.
  - Each round: w0' = w0 ^ SubWord(RotWord(w3)) ^ Rcon[cnt]; wi' = wi ^ w(i-1)' for i = 1..3.
- **Key schedule, `KEY_BITS`=256:**
  - 256-bit window. rk0 = key[255:128] and rk1 = key[127:0].
  - For rk[i], i ≥ 2, the window advances by one 128-bit half per round:
    - Even i: new half uses SubWord(RotWord(last word)) ^ Rcon[i/2].
    - Odd i: new half uses SubWord(last word), with no Rotate and no Rcon.
    - Remaining words in the half are chained XOR, as in AES-128.
- **Shared logic:**
  - S-box lookups use the team's existing S-box.
  - 16 lookups for the state plus 4 for the key per cycle.
  - Rcon is generated by xtime from 0x01, reset at accept.
- **Input sampling:**
  - Inputs are sampled only at accept.
  - Changes on `i_AES_plain_text`/`i_AES_key_in` while in ROUND or DONE are ignored.
  - `i_AES_valid` outside IDLE is ignored; there is no queueing.
- **Key handling:** no key caching; every block carries its own key.

## Timing
- **Reset values:**
  - `o_AES_valid`=0.
  - `o_AES_data_encrypted`=128'h0.
  - `o_AES_ready`=1 (FSM in IDLE).
  - Counter, state and key window are 0.
- **Latency:**
  - The accept edge is edge 0.
  - `o_AES_valid` rises after edge `NR`: 10 cycles for AES-128, 14 cycles for AES-256.
- **Throughput:**
  - If `i_AES_ready` is high when `o_AES_valid` rises, the DONE→IDLE transition happens on edge `NR`+1.
  - `o_AES_ready` rises after that edge, so the next accept is at the earliest on edge `NR`+2.
  - Minimum period is `NR`+2 cycles per block.
- **Backpressure:** DONE holds indefinitely while `i_AES_ready`=0; the output must not change.
- **Output ordering:** `o_AES_valid` and `o_AES_ready` are never high in the same cycle.
- **Reset mid-operation:** asynchronous reset in ROUND or DONE aborts immediately and all outputs take their reset values. The partial result is discarded, and no `o_AES_valid` pulse appears after reset is released.
- **Early sink ready:** `i_AES_ready` high before DONE has no effect.
- **Registered outputs:** `o_AES_data_encrypted` changes only on entry to DONE or on reset. `o_AES_ready`/`o_AES_valid` decode directly from state registers and have no combinational path from any input.

## Test plan
- **FIPS-197 App. B, `KEY_BITS`=128:**
  - Stimulus: pt 3243f6a8885a308d313198a2e0370734, key 2b7e151628aed2a6abf7158809cf4f3c, `i_AES_ready`=1.
  - Required: `o_AES_data_encrypted`=3925841d02dc09fbdc118597196a0b32, with `o_AES_valid` exactly 10 cycles after accept.
- **FIPS-197 C.3, `KEY_BITS`=256:**
  - Stimulus: pt 00112233445566778899aabbccddeeff, key 000102…1e1f.
  - Required: 8ea2b7ca516745bfeafc49904b496089 after 14 cycles.
- **Backpressure:**
  - Stimulus: C.1 vector (key 000102…0f), with `i_AES_ready`=0 for 7 cycles after `o_AES_valid`.
  - Required: output stays 69c4e0d86a7b0430d8cdb78070b4c55a and `o_AES_valid` stays high. The handshake completes in 1 cycle, and `o_AES_ready` returns the next cycle.
- **Input-change immunity:**
  - Stimulus: accept the App. B vector, then change pt/key to all-ones and hold `i_AES_valid`=1 during ROUND.
  - Required: result is still 3925841d…0b32, and a second block is accepted only once IDLE is reached.
- **Back-to-back:**
  - Stimulus: stream App. B then C.1 with `i_AES_valid`=1 continuously and `i_AES_ready`=1.
  - Required: both correct results, with accepts exactly 12 cycles apart.
- **Reset mid-round:**
  - Stimulus: assert `i_AES_rst_n`=0 at round 5 for 3 ns, asynchronously relative to the clock.
  - Required: outputs go immediately to 0/0/ready=1, with no spurious valid. A subsequent App. B block still yields 3925841d…0b32.

Source files
------------

// File: rtl/aes_iter_core.sv
`default_nettype none
// ============================================================================
// Module   : aes_iter_core
// Purpose  : Iterative AES-128/AES-256 encryptor, one round per clock with
//            on-the-fly key expansion and valid/ready handshakes on both sides.
// Revision : 1.0
// ============================================================================

module aes_iter_core #(
    parameter int KEY_BITS = 128
) (
    input  logic                i_AES_clk,
    input  logic                i_AES_rst_n,
    input  logic                i_AES_valid,
    output logic                o_AES_ready,
    input  logic [127:0]        i_AES_plain_text,
    input  logic [KEY_BITS-1:0] i_AES_key_in,
    output logic                o_AES_valid,
    input  logic                i_AES_ready,
    output logic [127:0]        o_AES_data_encrypted
);

    localparam int         c_NR       = (KEY_BITS == 256) ? 14 : 10;
    localparam logic [3:0] c_NR_CNT   = 4'(c_NR);
    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_ROUND = 2'd1;
    localparam logic [1:0] c_ST_DONE  = 2'd2;

    localparam logic [7:0] c_SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    generate
        if (KEY_BITS != 128 && KEY_BITS != 256) begin : g_bad_key_bits
            $error("aes_iter_core: KEY_BITS must be 128 or 256");
        end
    endgenerate

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] mix_col(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        a0 = c[31:24];
        a1 = c[23:16];
        a2 = c[15:8];
        a3 = c[7:0];
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    logic [1:0]          r_fsm;
    logic [1:0]          w_fsm_next;
    logic [127:0]        r_state;
    logic [127:0]        r_dout;
    logic [KEY_BITS-1:0] r_key_win;
    logic [KEY_BITS-1:0] w_win_next;
    logic [3:0]          r_cnt;
    logic [7:0]          r_rcon;
    logic                w_accept;
    logic                w_final;
    logic                w_rcon_step;
    logic [127:0]        w_sub;
    logic [127:0]        w_shift;
    logic [127:0]        w_mix;
    logic [127:0]        w_rk;
    logic [127:0]        w_round;
    logic [31:0]         w_last;
    logic [31:0]         w_last_sub;

    // Byte i of a 128-bit block sits at bits [127-8i -: 8]
    generate
        for (genvar i = 0; i < 16; i++) begin : g_sbox_state
            assign w_sub[127-8*i -: 8] = c_SBOX[r_state[127-8*i -: 8]];
        end
        for (genvar j = 0; j < 4; j++) begin : g_sbox_key
            assign w_last_sub[31-8*j -: 8] = c_SBOX[w_last[31-8*j -: 8]];
        end
    endgenerate

    always_comb begin
        w_shift = '0;
        w_mix   = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                w_shift[127-8*(r+4*c) -: 8] = w_sub[127-8*(r+4*((c+r)%4)) -: 8];
            end
        end
        for (int c = 0; c < 4; c++) begin
            w_mix[127-32*c -: 32] = mix_col(w_shift[127-32*c -: 32]);
        end
    end

    assign w_final = (r_cnt == c_NR_CNT);
    assign w_round = (w_final ? w_shift : w_mix) ^ w_rk;

    generate
        if (KEY_BITS == 128) begin : g_ks128
            logic [31:0] w_t, w_n0, w_n1, w_n2, w_n3;
            assign w_last      = r_key_win[31:0];
            assign w_t         = {w_last_sub[23:0], w_last_sub[31:24]} ^ {r_rcon, 24'h0};
            assign w_n0        = r_key_win[127:96] ^ w_t;
            assign w_n1        = r_key_win[95:64]  ^ w_n0;
            assign w_n2        = r_key_win[63:32]  ^ w_n1;
            assign w_n3        = r_key_win[31:0]   ^ w_n2;
            assign w_rk        = {w_n0, w_n1, w_n2, w_n3};
            assign w_win_next  = w_rk;
            assign w_rcon_step = 1'b1;
        end else begin : g_ks256
            // Window is {rk[i-2], rk[i-1]}; round 1 consumes the key's low half as-is
            logic [31:0]  w_t, w_n0, w_n1, w_n2, w_n3;
            logic [127:0] w_new;
            logic         w_first;
            assign w_last      = r_key_win[31:0];
            assign w_t         = r_cnt[0] ? w_last_sub
                                          : ({w_last_sub[23:0], w_last_sub[31:24]} ^ {r_rcon, 24'h0});
            assign w_n0        = r_key_win[255:224] ^ w_t;
            assign w_n1        = r_key_win[223:192] ^ w_n0;
            assign w_n2        = r_key_win[191:160] ^ w_n1;
            assign w_n3        = r_key_win[159:128] ^ w_n2;
            assign w_new       = {w_n0, w_n1, w_n2, w_n3};
            assign w_first     = (r_cnt == 4'd1);
            assign w_rk        = w_first ? r_key_win[127:0] : w_new;
            assign w_win_next  = w_first ? r_key_win : {r_key_win[127:0], w_new};
            assign w_rcon_step = ~r_cnt[0];
        end
    endgenerate

    assign w_accept = i_AES_valid && o_AES_ready;

    always_ff @(posedge i_AES_clk or negedge i_AES_rst_n) begin
        if (!i_AES_rst_n) begin
            r_fsm <= c_ST_IDLE;
        end else begin
            r_fsm <= w_fsm_next;
        end
    end

    always_comb begin
        w_fsm_next = r_fsm;
        case (r_fsm)
            c_ST_IDLE:  if (i_AES_valid) w_fsm_next = c_ST_ROUND;
            c_ST_ROUND: if (w_final)     w_fsm_next = c_ST_DONE;
            c_ST_DONE:  if (i_AES_ready) w_fsm_next = c_ST_IDLE;
            default:                     w_fsm_next = c_ST_IDLE;
        endcase
    end

    always_comb begin
        o_AES_ready = 1'b0;
        o_AES_valid = 1'b0;
        case (r_fsm)
            c_ST_IDLE: o_AES_ready = 1'b1;
            c_ST_DONE: o_AES_valid = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge i_AES_clk or negedge i_AES_rst_n) begin
        if (!i_AES_rst_n) begin
            r_state   <= '0;
            r_key_win <= '0;
            r_cnt     <= '0;
            r_rcon    <= '0;
            r_dout    <= '0;
        end else if (w_accept) begin
            r_state   <= i_AES_plain_text ^ i_AES_key_in[KEY_BITS-1 -: 128];
            r_key_win <= i_AES_key_in;
            r_cnt     <= 4'd1;
            r_rcon    <= 8'h01;
        end else if (r_fsm == c_ST_ROUND) begin
            r_state   <= w_round;
            r_key_win <= w_win_next;
            r_cnt     <= r_cnt + 4'd1;
            if (w_rcon_step) r_rcon <= xtime(r_rcon);
            if (w_final)     r_dout <= w_round;
        end
    end

    assign o_AES_data_encrypted = r_dout;

endmodule

`default_nettype wire

// File: tb/tb_aes_iter_core.sv
`default_nettype none
// ============================================================================
// Module   : tb_aes_iter_core
// Purpose  : Directed and randomized checks of aes_iter_core (AES-128 and
//            AES-256 instances) against a byte-level FIPS-197 reference.
// Revision : 1.0
// ============================================================================

module tb_aes_iter_core;

    localparam logic [127:0] c_PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] c_KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] c_CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] c_PT_C  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] c_KEY_C1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] c_CT_C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [255:0] c_KEY_C3 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] c_CT_C3 = 128'h8ea2b7ca516745bfeafc49904b496089;

    logic         clk;
    logic         r_rst_n;
    logic         r_sel;
    logic         r_ready;
    logic         r_valid_a, r_valid_b;
    logic [127:0] r_pt_a, r_pt_b;
    logic [127:0] r_key_a;
    logic [255:0] r_key_b;
    logic         w_oready_a, w_ovalid_a, w_oready_b, w_ovalid_b;
    logic [127:0] w_data_a, w_data_b;
    logic         w_mvalid, w_mready;
    logic [127:0] w_mdata;

    int n_assert;
    int n_fail;
    logic [7:0] m_sbox [256];

    aes_iter_core #(.KEY_BITS(128)) dut_a (
        .i_AES_clk(clk), .i_AES_rst_n(r_rst_n),
        .i_AES_valid(r_valid_a), .o_AES_ready(w_oready_a),
        .i_AES_plain_text(r_pt_a), .i_AES_key_in(r_key_a),
        .o_AES_valid(w_ovalid_a), .i_AES_ready(r_ready),
        .o_AES_data_encrypted(w_data_a)
    );

    aes_iter_core #(.KEY_BITS(256)) dut_b (
        .i_AES_clk(clk), .i_AES_rst_n(r_rst_n),
        .i_AES_valid(r_valid_b), .o_AES_ready(w_oready_b),
        .i_AES_plain_text(r_pt_b), .i_AES_key_in(r_key_b),
        .o_AES_valid(w_ovalid_b), .i_AES_ready(r_ready),
        .o_AES_data_encrypted(w_data_b)
    );

    assign w_mvalid = r_sel ? w_ovalid_b : w_ovalid_a;
    assign w_mready = r_sel ? w_oready_b : w_oready_a;
    assign w_mdata  = r_sel ? w_data_b   : w_data_a;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: plain GF(2^8) arithmetic and the textbook FIPS-197 cipher
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int k);
        logic [15:0] t;
        t = {b, b} << k;
        return t[15:8];
    endfunction

    task automatic build_sbox();
        logic [7:0] inv, xb;
        for (int x = 0; x < 256; x++) begin
            xb  = 8'(x);
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (gmul(xb, 8'(y)) == 8'h01) inv = 8'(y);
            end
            m_sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] subword(input logic [31:0] x);
        return {m_sbox[x[31:24]], m_sbox[x[23:16]], m_sbox[x[15:8]], m_sbox[x[7:0]]};
    endfunction

    // key is left-aligned: an AES-128 key occupies bits [255:128]
    function automatic logic [127:0] ref_encrypt(input logic [255:0] key, input int nk,
                                                 input logic [127:0] pt);
        logic [31:0]  w [60];
        logic [31:0]  temp;
        logic [7:0]   rc, a0, a1, a2, a3;
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [127:0] ct;
        int nr;
        nr = nk + 6;
        for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
        for (int i = nk; i < 4*(nr+1); i++) begin
            temp = w[i-1];
            if (i % nk == 0) begin
                rc = 8'h01;
                for (int k = 1; k < i/nk; k++) rc = gmul(rc, 8'h02);
                temp = subword({temp[23:0], temp[31:24]}) ^ {rc, 24'h0};
            end else if (nk > 6 && i % nk == 4) begin
                temp = subword(temp);
            end
            w[i] = w[i-nk] ^ temp;
        end
        for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
        for (int rd = 1; rd <= nr; rd++) begin
            for (int i = 0; i < 16; i++) s[i] = m_sbox[s[i]];
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++) t[r+4*c] = s[r+4*((c+r)%4)];
            s = t;
            if (rd < nr) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
                    s[4*c]   = gmul(8'h02, a0) ^ gmul(8'h03, a1) ^ a2 ^ a3;
                    s[4*c+1] = a0 ^ gmul(8'h02, a1) ^ gmul(8'h03, a2) ^ a3;
                    s[4*c+2] = a0 ^ a1 ^ gmul(8'h02, a2) ^ gmul(8'h03, a3);
                    s[4*c+3] = gmul(8'h03, a0) ^ a1 ^ a2 ^ gmul(8'h02, a3);
                end
            end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[4*rd + i/4][31-8*(i%4) -: 8];
        end
        for (int i = 0; i < 16; i++) ct[127-8*i -: 8] = s[i];
        return ct;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [127:0] pt, input logic [255:0] key);
        if (r_sel) begin
            r_valid_b = v; r_pt_b = pt; r_key_b = key;
        end else begin
            r_valid_a = v; r_pt_a = pt; r_key_a = key[255:128];
        end
    endtask

    // Returns the number of edges after the accept edge until valid is seen
    task automatic wait_valid(output int lat);
        lat = 0;
        while (!w_mvalid && lat < 40) begin
            tick();
            lat++;
            chk("valid_and_ready_exclusive", {126'd0, w_mvalid, w_mready}, {126'd0, w_mvalid, 1'b0});
        end
    endtask

    task automatic run_check(input string tag, input logic [127:0] pt, input logic [255:0] key,
                             input logic [127:0] exp, input int hold);
        int lat, nr;
        nr = r_sel ? 14 : 10;
        r_ready = (hold == 0);
        chk({tag, "_ready_before"}, w_mready, 1);
        drive(1'b1, pt, key);
        tick();
        drive(1'b0, {$urandom, $urandom, $urandom, $urandom}, {8{$urandom}});
        chk({tag, "_ready_after_accept"}, w_mready, 0);
        wait_valid(lat);
        chk({tag, "_latency"}, lat, nr);
        chk({tag, "_data"}, w_mdata, exp);
        for (int h = 0; h < hold; h++) begin
            tick();
            chk({tag, "_hold_valid"}, w_mvalid, 1);
            chk({tag, "_hold_data"}, w_mdata, exp);
        end
        r_ready = 1'b1;
        tick();
        chk({tag, "_valid_drop"}, w_mvalid, 0);
        chk({tag, "_ready_back"}, w_mready, 1);
    endtask

    initial begin
        int lat, spurious, hold;
        logic [127:0] pt, exp;
        logic [255:0] key;
        n_assert = 0;
        n_fail   = 0;
        build_sbox();
        r_rst_n = 1'b0; r_sel = 1'b0; r_ready = 1'b1;
        r_valid_a = 1'b0; r_valid_b = 1'b0;
        r_pt_a = '0; r_pt_b = '0; r_key_a = '0; r_key_b = '0;
        #2;
        chk("rst_valid_a", w_ovalid_a, 0);
        chk("rst_ready_a", w_oready_a, 1);
        chk("rst_data_a",  w_data_a,   0);
        chk("rst_valid_b", w_ovalid_b, 0);
        chk("rst_ready_b", w_oready_b, 1);
        chk("rst_data_b",  w_data_b,   0);
        #10 r_rst_n = 1'b1;
        tick();

        r_sel = 1'b0;
        run_check("appB", c_PT_B, {c_KEY_B, 128'h0}, c_CT_B, 0);
        r_sel = 1'b1;
        run_check("c3", c_PT_C, c_KEY_C3, c_CT_C3, 0);
        r_sel = 1'b0;
        run_check("c1_backpressure", c_PT_C, {c_KEY_C1, 128'h0}, c_CT_C1, 7);

        // Input-change immunity: garbage with valid held high during ROUND
        r_ready = 1'b1;
        drive(1'b1, c_PT_B, {c_KEY_B, 128'h0});
        tick();
        drive(1'b1, '1, '1);
        wait_valid(lat);
        chk("immune_latency", lat, 10);
        chk("immune_data", w_mdata, c_CT_B);
        tick();
        chk("immune_idle_ready", w_mready, 1);
        chk("immune_idle_valid", w_mvalid, 0);
        tick();
        chk("immune_second_accept", w_mready, 0);
        drive(1'b0, '0, '0);
        wait_valid(lat);
        chk("immune_second_data", w_mdata, ref_encrypt('1, 4, '1));
        tick();

        // Back-to-back stream: accepts land 12 edges apart
        drive(1'b1, c_PT_B, {c_KEY_B, 128'h0});
        tick();
        drive(1'b1, c_PT_C, {c_KEY_C1, 128'h0});
        wait_valid(lat);
        chk("b2b_first_latency", lat, 10);
        chk("b2b_first_data", w_mdata, c_CT_B);
        tick();
        chk("b2b_ready_edge11", w_mready, 1);
        tick();
        chk("b2b_accept_edge12", w_mready, 0);
        drive(1'b0, '0, '0);
        wait_valid(lat);
        chk("b2b_second_latency", lat, 10);
        chk("b2b_second_data", w_mdata, c_CT_C1);
        tick();

        // Asynchronous reset during round 5
        drive(1'b1, c_PT_B, {c_KEY_B, 128'h0});
        tick();
        drive(1'b0, '0, '0);
        repeat (4) tick();
        #2 r_rst_n = 1'b0;
        #1;
        chk("midrst_valid", w_ovalid_a, 0);
        chk("midrst_ready", w_oready_a, 1);
        chk("midrst_data",  w_data_a,   0);
        chk("midrst_data_b", w_data_b,  0);
        #2 r_rst_n = 1'b1;
        spurious = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (w_ovalid_a) spurious++;
        end
        chk("midrst_no_spurious_valid", spurious, 0);
        run_check("appB_after_reset", c_PT_B, {c_KEY_B, 128'h0}, c_CT_B, 0);

        for (int k = 0; k < 8; k++) begin
            r_sel = k[0];
            pt    = {$urandom, $urandom, $urandom, $urandom};
            key   = {8{$urandom}};
            hold  = $urandom_range(0, 3);
            exp   = ref_encrypt(key, r_sel ? 8 : 4, pt);
            run_check(r_sel ? "rand256" : "rand128", pt, key, exp, hold);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
